// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the issue scheduler: instruction field layout,
// memory-op opcode and halt/drain state encoding.
package issue_scheduler_pkg;

  localparam int INSTR_W  = 32;

  // Instruction field positions (LSB of each field)
  localparam int OPC_LSB  = 29;
  localparam int OPC_W    = 3;
  localparam int DEST_LSB = 0;
  localparam int SRCA_LSB = 11;
  localparam int SRCB_LSB = 5;
  localparam int IMM_BIT  = 10;

  // Opcode of memory ops that compete for the single shared memory port
  localparam logic [OPC_W-1:0] MEM_OPC_DEFAULT = 3'b111;

  // Halt/drain state machine encoding
  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_HALT_PENDING = 2'd1,
    ST_HALTED       = 2'd2
  } sched_state_e;

  // Opcode field of an instruction word
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/issue_scheduler_hazard_check.sv
// Per-lane decode and scoreboard hazard check for one FIFO head.
// Flags the head hazard-free when none of its read registers and its
// written register are marked busy in the registered scoreboard.
module issue_scheduler_hazard_check
  import issue_scheduler_pkg::*;
#(
  parameter int               REG_W   = 5,
  parameter logic [OPC_W-1:0] MEM_OPC = MEM_OPC_DEFAULT
) (
  input  logic [INSTR_W-1:0]     instr,
  input  logic [(1<<REG_W)-1:0]  busy,
  output logic                   hazard_free,
  output logic                   is_mem,
  output logic [REG_W-1:0]       dest,
  output logic                   dest_used,
  output logic [REG_W-1:0]       src_a,
  output logic [REG_W-1:0]       src_b,
  output logic                   src_b_used
);

  // Field decode; register 0 is a sink and never tracked as a destination
  always_comb begin
    dest       = instr[DEST_LSB +: REG_W];
    src_a      = instr[SRCA_LSB +: REG_W];
    src_b      = instr[SRCB_LSB +: REG_W];
    src_b_used = ~instr[IMM_BIT];
    dest_used  = |dest;
    is_mem     = (opcode_of(instr) == MEM_OPC);
  end

  // RAW on either source or WAW on the destination blocks the head
  always_comb begin
    hazard_free = ~busy[src_a]
                & ~(src_b_used & busy[src_b])
                & ~(dest_used & busy[dest]);
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue controller between the two instruction FIFOs and the two execution
// lanes. Combinational issue decision from the FIFO heads, the registered
// busy scoreboard, a round-robin pointer for the shared memory port and
// same-cycle cross-lane conflicts, plus a halt/drain state machine.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int               REG_W   = 5,
  parameter int               CNT_W   = 16,
  parameter logic [OPC_W-1:0] MEM_OPC = 3'b111
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [31:0]        fifo1_data,
  input  logic [31:0]        fifo2_data,
  input  logic               fifo1_empty,
  input  logic               fifo2_empty,
  output logic               fifo1_pop,
  output logic               fifo2_pop,
  output logic               lane1_valid,
  output logic               lane2_valid,
  output logic [31:0]        lane1_instr,
  output logic [31:0]        lane2_instr,
  input  logic               lane1_ready,
  input  logic               lane2_ready,
  input  logic               wb1_valid,
  input  logic               wb2_valid,
  input  logic [REG_W-1:0]   wb1_addr,
  input  logic [REG_W-1:0]   wb2_addr,
  input  logic               halt_req,
  output logic               halt_ack,
  output logic [CNT_W-1:0]   lane1_stalls,
  output logic [CNT_W-1:0]   lane2_stalls
);

  localparam int NREG = 1 << REG_W;

  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_next;
  logic             rr;
  sched_state_e     state;

  logic             hf1, hf2;
  logic             mem1, mem2;
  logic [REG_W-1:0] dest1, dest2, srca1, srca2, srcb1, srcb2;
  logic             dest1_used, dest2_used, srcb1_used, srcb2_used;

  logic             run;
  logic             cand1, cand2;
  logic             conflict;

  // Saturating increment for the stall counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // True when a tracked destination is read or written by the other head
  function automatic logic writes_into(
    input logic             d_used,
    input logic [REG_W-1:0] d,
    input logic [REG_W-1:0] o_dest,
    input logic [REG_W-1:0] o_srca,
    input logic             o_srcb_used,
    input logic [REG_W-1:0] o_srcb
  );
    return d_used & ((d == o_dest) | (d == o_srca) | (o_srcb_used & (d == o_srcb)));
  endfunction

  issue_scheduler_hazard_check #(
    .REG_W   (REG_W),
    .MEM_OPC (MEM_OPC)
  ) u_hazard_check_l1 (
    .instr       (fifo1_data),
    .busy        (busy),
    .hazard_free (hf1),
    .is_mem      (mem1),
    .dest        (dest1),
    .dest_used   (dest1_used),
    .src_a       (srca1),
    .src_b       (srcb1),
    .src_b_used  (srcb1_used)
  );

  issue_scheduler_hazard_check #(
    .REG_W   (REG_W),
    .MEM_OPC (MEM_OPC)
  ) u_hazard_check_l2 (
    .instr       (fifo2_data),
    .busy        (busy),
    .hazard_free (hf2),
    .is_mem      (mem2),
    .dest        (dest2),
    .dest_used   (dest2_used),
    .src_a       (srca2),
    .src_b       (srcb2),
    .src_b_used  (srcb2_used)
  );

  // Issue decision: candidates, cross-lane conflict and round-robin loser masking.
  // Outputs are forced low while reset is asserted.
  always_comb begin
    run      = (state == ST_RUN);
    cand1    = ~fifo1_empty & run & hf1;
    cand2    = ~fifo2_empty & run & hf2;
    conflict = cand1 & cand2 &
               ((mem1 & mem2) |
                writes_into(dest1_used, dest1, dest2, srca2, srcb2_used, srcb2) |
                writes_into(dest2_used, dest2, dest1, srca1, srcb1_used, srcb1));
    lane1_valid = resetn & cand1 & ~(conflict & rr);
    lane2_valid = resetn & cand2 & ~(conflict & ~rr);
    fifo1_pop   = lane1_valid & lane1_ready;
    fifo2_pop   = lane2_valid & lane2_ready;
    lane1_instr = fifo1_data;
    lane2_instr = fifo2_data;
  end

  // Next scoreboard: writebacks clear, issues set; a set overrides a clear
  always_comb begin
    busy_next = busy;
    if (wb1_valid && (wb1_addr != '0)) busy_next[wb1_addr] = 1'b0;
    if (wb2_valid && (wb2_addr != '0)) busy_next[wb2_addr] = 1'b0;
    if (fifo1_pop && dest1_used)       busy_next[dest1]    = 1'b1;
    if (fifo2_pop && dest2_used)       busy_next[dest2]    = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) busy <= '0;
    else         busy <= busy_next;
  end

  // Round-robin pointer: flips when the conflict winner issues, and after an
  // uncontended memory issue points at the other lane
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr <= 1'b0;
    end else if (conflict) begin
      if (rr ? fifo2_pop : fifo1_pop) rr <= ~rr;
    end else if (fifo1_pop && mem1) begin
      rr <= 1'b1;
    end else if (fifo2_pop && mem2) begin
      rr <= 1'b0;
    end
  end

  // Halt/drain state machine with registered acknowledge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_RUN;
      halt_ack <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          halt_ack <= 1'b0;
          if (halt_req) state <= ST_HALT_PENDING;
        end
        ST_HALT_PENDING: begin
          if (!halt_req) begin
            state    <= ST_RUN;
            halt_ack <= 1'b0;
          end else if (busy == '0) begin
            state    <= ST_HALTED;
            halt_ack <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            state    <= ST_RUN;
            halt_ack <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RUN;
          halt_ack <= 1'b0;
        end
      endcase
    end
  end

  // Per-lane stall counters: head present but not popped, in any state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane1_stalls <= '0;
      lane2_stalls <= '0;
    end else begin
      if (!fifo1_empty && !fifo1_pop) lane1_stalls <= sat_inc(lane1_stalls);
      if (!fifo2_empty && !fifo2_pop) lane2_stalls <= sat_inc(lane2_stalls);
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Testbench for issue_scheduler: directed scenarios plus randomized traffic
// checked against a behavioural model of the issue rules.
module tb_issue_scheduler;

  localparam int TB_CNT_W = 4;
  localparam int SAT      = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                resetn;
  logic [31:0]         fifo1_data, fifo2_data;
  logic                fifo1_empty, fifo2_empty;
  logic                fifo1_pop, fifo2_pop;
  logic                lane1_valid, lane2_valid;
  logic [31:0]         lane1_instr, lane2_instr;
  logic                lane1_ready, lane2_ready;
  logic                wb1_valid, wb2_valid;
  logic [4:0]          wb1_addr, wb2_addr;
  logic                halt_req;
  logic                halt_ack;
  logic [TB_CNT_W-1:0] lane1_stalls, lane2_stalls;

  int checks = 0;
  int fails  = 0;

  // Behavioural model state
  bit [31:0] mbusy;
  bit        mrr;
  int        mstate;   // 0 run, 1 halt pending, 2 halted
  int        mst1, mst2;
  bit        e_v1, e_v2, e_p1, e_p2, e_conf;

  issue_scheduler #(.REG_W(5), .CNT_W(TB_CNT_W), .MEM_OPC(3'b111)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .fifo1_data   (fifo1_data),
    .fifo2_data   (fifo2_data),
    .fifo1_empty  (fifo1_empty),
    .fifo2_empty  (fifo2_empty),
    .fifo1_pop    (fifo1_pop),
    .fifo2_pop    (fifo2_pop),
    .lane1_valid  (lane1_valid),
    .lane2_valid  (lane2_valid),
    .lane1_instr  (lane1_instr),
    .lane2_instr  (lane2_instr),
    .lane1_ready  (lane1_ready),
    .lane2_ready  (lane2_ready),
    .wb1_valid    (wb1_valid),
    .wb2_valid    (wb2_valid),
    .wb1_addr     (wb1_addr),
    .wb2_addr     (wb2_addr),
    .halt_req     (halt_req),
    .halt_ack     (halt_ack),
    .lane1_stalls (lane1_stalls),
    .lane2_stalls (lane2_stalls)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int opc, input int d, input int sa, input int sb, input bit imm);
    logic [31:0] r;
    r        = '0;
    r[31:29] = opc[2:0];
    r[4:0]   = d[4:0];
    r[15:11] = sa[4:0];
    r[9:5]   = sb[4:0];
    r[10]    = imm;
    return r;
  endfunction

  function automatic bit is_mem(input logic [31:0] i);
    return i[31:29] == 3'b111;
  endfunction

  function automatic bit is_free(input logic [31:0] i);
    int d, sa, sb;
    d  = int'(i[4:0]);
    sa = int'(i[15:11]);
    sb = int'(i[9:5]);
    if (mbusy[sa]) return 0;
    if (!i[10] && mbusy[sb]) return 0;
    if (d != 0 && mbusy[d]) return 0;
    return 1;
  endfunction

  // a writes a register that b reads or writes
  function automatic bit clash(input logic [31:0] a, input logic [31:0] b);
    int d;
    d = int'(a[4:0]);
    if (d == 0) return 0;
    return (d == int'(b[4:0])) || (d == int'(b[15:11])) || (!b[10] && d == int'(b[9:5]));
  endfunction

  task automatic model_reset();
    mbusy = '0; mrr = 0; mstate = 0; mst1 = 0; mst2 = 0;
  endtask

  task automatic model_comb();
    bit c1, c2;
    e_v1 = 0; e_v2 = 0; e_p1 = 0; e_p2 = 0; e_conf = 0;
    if (!resetn) return;
    c1 = !fifo1_empty && mstate == 0 && is_free(fifo1_data);
    c2 = !fifo2_empty && mstate == 0 && is_free(fifo2_data);
    e_conf = c1 && c2 && ((is_mem(fifo1_data) && is_mem(fifo2_data)) ||
                          clash(fifo1_data, fifo2_data) || clash(fifo2_data, fifo1_data));
    e_v1 = c1 && !(e_conf && mrr);
    e_v2 = c2 && !(e_conf && !mrr);
    e_p1 = e_v1 && lane1_ready;
    e_p2 = e_v2 && lane2_ready;
  endtask

  task automatic model_clock();
    bit allzero;
    if (!resetn) begin model_reset(); return; end
    allzero = (mbusy == '0);
    if (wb1_valid && wb1_addr != 0) mbusy[wb1_addr] = 0;
    if (wb2_valid && wb2_addr != 0) mbusy[wb2_addr] = 0;
    if (e_p1 && fifo1_data[4:0] != 0) mbusy[fifo1_data[4:0]] = 1;
    if (e_p2 && fifo2_data[4:0] != 0) mbusy[fifo2_data[4:0]] = 1;
    if (e_conf) begin
      if (mrr ? e_p2 : e_p1) mrr = !mrr;
    end else if (e_p1 && is_mem(fifo1_data)) mrr = 1;
    else if (e_p2 && is_mem(fifo2_data)) mrr = 0;
    case (mstate)
      0: if (halt_req) mstate = 1;
      1: if (!halt_req) mstate = 0; else if (allzero) mstate = 2;
      default: if (!halt_req) mstate = 0;
    endcase
    if (!fifo1_empty && !e_p1 && mst1 < SAT) mst1++;
    if (!fifo2_empty && !e_p2 && mst2 < SAT) mst2++;
  endtask

  task automatic idle_inputs();
    fifo1_data = '0; fifo2_data = '0;
    fifo1_empty = 1; fifo2_empty = 1;
    lane1_ready = 1; lane2_ready = 1;
    wb1_valid = 0; wb2_valid = 0; wb1_addr = '0; wb2_addr = '0;
    halt_req = 0;
  endtask

  task automatic settle();
    #2;
    model_comb();
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    resetn = 0;
    model_reset();
    tick();
    tick();
    resetn = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    model_reset();
    fifo1_empty = 0;
    fifo1_data  = mk(0, 3, 1, 2, 0);
    settle();
    if ({lane1_valid, fifo1_pop, lane2_valid, fifo2_pop} !== 4'b0000) begin
      fails++; $display("FAIL reset_strobes got %b expected 0000", {lane1_valid, fifo1_pop, lane2_valid, fifo2_pop});
    end
    checks++;
    tick();
    if (halt_ack !== 1'b0) begin fails++; $display("FAIL reset_halt_ack got %b expected 0", halt_ack); end
    checks++;
    if ({lane1_stalls, lane2_stalls} !== '0) begin
      fails++; $display("FAIL reset_stalls got %0d/%0d expected 0/0", lane1_stalls, lane2_stalls);
    end
    checks++;
    resetn = 1;
    settle();
    if ({lane1_valid, fifo1_pop} !== 2'b11) begin
      fails++; $display("FAIL reset_release_issue got %b expected 11", {lane1_valid, fifo1_pop});
    end
    checks++;
    tick();
  endtask

  task automatic test_single_issue();
    apply_reset();
    fifo1_empty = 0;
    fifo1_data  = 32'h0004_5678;
    settle();
    if ({lane1_valid, fifo1_pop, lane2_valid} !== 3'b110) begin
      fails++; $display("FAIL single_issue got %b expected 110", {lane1_valid, fifo1_pop, lane2_valid});
    end
    checks++;
    if (lane1_instr !== 32'h0004_5678) begin
      fails++; $display("FAIL single_instr got %h expected 00045678", lane1_instr);
    end
    checks++;
    tick();
    fifo1_data = mk(0, 1, 24, 0, 1);
    settle();
    if (lane1_valid !== 1'b0) begin fails++; $display("FAIL busy24_blocks got %b expected 0", lane1_valid); end
    checks++;
    tick();
  endtask

  task automatic test_raw_stall();
    apply_reset();
    fifo1_empty = 0;
    fifo1_data  = mk(0, 21, 1, 2, 0);
    settle();
    if (lane1_valid !== 1'b1) begin fails++; $display("FAIL raw_first got %b expected 1", lane1_valid); end
    checks++;
    tick();
    fifo1_data = mk(0, 5, 21, 0, 1);
    for (int k = 0; k < 3; k++) begin
      settle();
      if ({lane1_valid, fifo1_pop} !== 2'b00) begin
        fails++; $display("FAIL raw_stall cyc %0d got %b expected 00", k, {lane1_valid, fifo1_pop});
      end
      checks++;
      tick();
    end
    wb1_valid = 1; wb1_addr = 5'd21;
    settle();
    if (lane1_valid !== 1'b0) begin fails++; $display("FAIL raw_no_bypass got %b expected 0", lane1_valid); end
    checks++;
    tick();
    wb1_valid = 0;
    settle();
    if ({lane1_valid, fifo1_pop} !== 2'b11) begin
      fails++; $display("FAIL raw_after_wb got %b expected 11", {lane1_valid, fifo1_pop});
    end
    checks++;
    if (lane1_stalls !== TB_CNT_W'(4)) begin fails++; $display("FAIL raw_stall_count got %0d expected 4", lane1_stalls); end
    checks++;
    tick();
  endtask

  task automatic test_mem_alternate();
    apply_reset();
    fifo1_empty = 0; fifo2_empty = 0;
    fifo1_data  = mk(7, 0, 2, 3, 0);
    fifo2_data  = mk(7, 0, 5, 6, 0);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp;
      exp = (k % 2 == 0) ? 2'b10 : 2'b01;
      settle();
      if ({lane1_valid, lane2_valid} !== exp) begin
        fails++; $display("FAIL mem_alt cyc %0d got %b expected %b", k, {lane1_valid, lane2_valid}, exp);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_cross_conflict();
    apply_reset();
    fifo1_empty = 0;
    fifo1_data  = mk(7, 0, 1, 2, 1);
    tick();
    fifo2_empty = 0;
    fifo1_data  = mk(0, 7, 9, 0, 1);
    fifo2_data  = mk(0, 9, 1, 2, 0);
    settle();
    if ({lane1_valid, lane2_valid} !== 2'b01) begin
      fails++; $display("FAIL conflict_rr1 got %b expected 01", {lane1_valid, lane2_valid});
    end
    checks++;
    tick();
    fifo1_data = mk(0, 12, 13, 0, 1);
    fifo2_data = mk(0, 14, 12, 0, 1);
    settle();
    if ({lane1_valid, lane2_valid} !== 2'b10) begin
      fails++; $display("FAIL conflict_rr0 got %b expected 10", {lane1_valid, lane2_valid});
    end
    checks++;
    tick();
  endtask

  task automatic test_halt_drain();
    apply_reset();
    fifo1_empty = 0; fifo2_empty = 0;
    fifo1_data  = mk(0, 3, 1, 2, 0);
    fifo2_data  = mk(0, 4, 5, 6, 0);
    tick();
    fifo1_empty = 1; fifo2_empty = 1;
    halt_req = 1;
    tick();
    fifo1_empty = 0; fifo2_empty = 0;
    fifo1_data  = mk(0, 0, 1, 2, 1);
    fifo2_data  = mk(0, 0, 1, 2, 1);
    wb1_valid = 1; wb1_addr = 5'd3;
    settle();
    if ({lane1_valid, lane2_valid, halt_ack} !== 3'b000) begin
      fails++; $display("FAIL halt_pending got %b expected 000", {lane1_valid, lane2_valid, halt_ack});
    end
    checks++;
    tick();
    wb1_valid = 0; wb2_valid = 1; wb2_addr = 5'd4;
    tick();
    wb2_valid = 0;
    settle();
    if (halt_ack !== 1'b0) begin fails++; $display("FAIL halt_ack_early got %b expected 0", halt_ack); end
    checks++;
    tick();
    halt_req = 0;
    settle();
    if ({lane1_valid, lane2_valid, halt_ack} !== 3'b001) begin
      fails++; $display("FAIL halted got %b expected 001", {lane1_valid, lane2_valid, halt_ack});
    end
    checks++;
    tick();
    settle();
    if ({lane1_valid, lane2_valid, halt_ack} !== 3'b110) begin
      fails++; $display("FAIL resume got %b expected 110", {lane1_valid, lane2_valid, halt_ack});
    end
    checks++;
    tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    fifo1_empty = 0;
    fifo1_data  = mk(0, 0, 0, 0, 1);
    lane1_ready = 0;
    for (int k = 0; k < 20; k++) tick();
    settle();
    if ({lane1_valid, fifo1_pop} !== 2'b10) begin
      fails++; $display("FAIL sat_strobes got %b expected 10", {lane1_valid, fifo1_pop});
    end
    checks++;
    if (lane1_stalls !== TB_CNT_W'(SAT)) begin
      fails++; $display("FAIL sat_count got %0d expected %0d", lane1_stalls, SAT);
    end
    checks++;
    lane1_ready = 1;
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    fifo1_empty = 0;
    fifo1_data  = mk(0, 6, 1, 2, 0);
    tick();
    fifo1_data = mk(0, 7, 6, 0, 1);
    for (int k = 0; k < 3; k++) tick();
    settle();
    if (lane1_stalls !== TB_CNT_W'(3)) begin fails++; $display("FAIL mid_pre_stalls got %0d expected 3", lane1_stalls); end
    checks++;
    resetn = 0;
    model_reset();
    settle();
    if ({lane1_valid, fifo1_pop, halt_ack} !== 3'b000 || lane1_stalls !== '0) begin
      fails++; $display("FAIL mid_reset got %b stalls %0d expected 000 stalls 0",
                        {lane1_valid, fifo1_pop, halt_ack}, lane1_stalls);
    end
    checks++;
    tick();
    resetn = 1;
    settle();
    if (lane1_valid !== 1'b1) begin fails++; $display("FAIL mid_busy_cleared got %b expected 1", lane1_valid); end
    checks++;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] rd;
    apply_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      fifo1_empty = ($urandom_range(0, 3) == 0);
      fifo2_empty = ($urandom_range(0, 3) == 0);
      rd = $urandom;
      fifo1_data = mk(($urandom_range(0, 2) == 0) ? 7 : $urandom_range(0, 6), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7), rd[0]);
      fifo2_data = mk(($urandom_range(0, 2) == 0) ? 7 : $urandom_range(0, 6), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7), rd[1]);
      fifo1_data[28:16] = rd[28:16];
      lane1_ready = ($urandom_range(0, 3) != 0);
      lane2_ready = ($urandom_range(0, 3) != 0);
      wb1_valid = rd[2]; wb1_addr = 5'($urandom_range(0, 7));
      wb2_valid = rd[3]; wb2_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) halt_req = !halt_req;
      settle();
      if ({lane1_valid, lane2_valid, fifo1_pop, fifo2_pop, halt_ack} !==
          {e_v1, e_v2, e_p1, e_p2, (mstate == 2)}) begin
        fails++; $display("FAIL rnd_ctrl cyc %0d got %b expected %b", cyc,
                          {lane1_valid, lane2_valid, fifo1_pop, fifo2_pop, halt_ack},
                          {e_v1, e_v2, e_p1, e_p2, (mstate == 2)});
      end
      checks++;
      if (lane1_stalls !== TB_CNT_W'(mst1) || lane2_stalls !== TB_CNT_W'(mst2)) begin
        fails++; $display("FAIL rnd_stalls cyc %0d got %0d/%0d expected %0d/%0d", cyc,
                          lane1_stalls, lane2_stalls, mst1, mst2);
      end
      checks++;
      if (lane1_instr !== fifo1_data || lane2_instr !== fifo2_data) begin
        fails++; $display("FAIL rnd_instr cyc %0d got %h/%h expected %h/%h", cyc,
                          lane1_instr, lane2_instr, fifo1_data, fifo2_data);
      end
      checks++;
      tick();
    end
    halt_req = 0;
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_issue();
    test_raw_stall();
    test_mem_alternate();
    test_cross_conflict();
    test_halt_drain();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Issue controller between the two instruction FIFOs (filled by the dispatch arbiter) and the two execution lanes. Each cycle it decides which FIFO heads may issue, using a register busy scoreboard (RAW/WAW hazards), a round-robin grant for the single shared memory port and same-cycle cross-lane conflicts, and a halt/drain state machine. It owns the FIFO pop strobes and the lane valid strobes.

## Interface
- REG_W, 5, register address width; scoreboard has 2**REG_W entries
- CNT_W, 16, width of per-lane stall counters
- MEM_OPC, 3'b111, opcode value (instr[31:29]) of memory ops that use the shared port

- clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- fifo1_data / fifo2_data  in  32  show-ahead head of FIFO1 / FIFO2
- fifo1_empty / fifo2_empty  in  1  FIFO empty flags
- fifo1_pop / fifo2_pop  out  1  pop head; equals laneN_valid & laneN_ready
- lane1_valid / lane2_valid  out  1  issue request to lane
- lane1_instr / lane2_instr  out  32  issued instruction (head passthrough)
- lane1_ready / lane2_ready  in  1  lane accepts this cycle
- wb1_valid, wb2_valid  in  1  writeback completes
- wb1_addr, wb2_addr  in  REG_W  register written back; clears busy bit
- halt_req  in  1  level request to stop issue and drain
- halt_ack  out  1  high in HALTED
- lane1_stalls / lane2_stalls  out  CNT_W  saturating count of cycles head present but not issued

## Operation
- Fields: opcode [31:29], dest [4:0], srcA [15:11], srcB [9:5] (used only when bit 10 = 0; bit 10 = 1 is immediate). dest 0 is never tracked.
- Lane N candidate: !fifoN_empty, state RUN, busy[srcA]=0, busy[srcB]=0 if used, busy[dest]=0 if dest≠0.
- Busy read is the registered value; no writeback bypass (one-cycle penalty after wb).
- Cross-lane conflict (both candidates and: both memory ops, or either dest≠0 equals the other's dest/srcA/used srcB): only lane at rr issues (rr=0 → lane1); rr toggles on each resolved conflict, and also after each uncontended memory grant it points away from the granted lane.
- laneN_valid = candidate & not losing conflict; laneN_instr = fifoN_data always.
- Issue commits at clock edge when valid & ready: busy[dest] set (dest≠0).
- wb1/wb2 clear busy[addr] at the edge; both may clear in one cycle; wb to addr 0 ignored. Set and clear of same bit in same cycle cannot occur (dest busy blocks issue); if it does, set wins.
- Stall counter N increments when !fifoN_empty & !(fifoN_pop); saturates at all-ones; increments in HALT_PENDING/HALTED too.
- FSM: RUN → HALT_PENDING on halt_req; HALT_PENDING → HALTED when scoreboard all zero; HALTED → RUN when halt_req low; HALT_PENDING → RUN if halt_req drops before drain.

## Timing
- Issue decision combinational, zero latency from head/ready to valid/pop.
- Scoreboard, rr, FSM, counters update on rising clk.
- Reset (any time, mid-issue included): busy all 0, rr=0, state RUN, halt_ack 0, counters 0; while resetn=0 all valid/pop outputs forced 0.
- halt_ack asserts the cycle after scoreboard reaches zero in HALT_PENDING; drops the cycle after halt_req deasserts.

## Structure
- Shared package: field bit positions, MEM_OPC, FSM state encoding (RUN, HALT_PENDING, HALTED).
- One sub-module: hazard_check (one instance per lane) — inputs instr, busy vector; output candidate-hazard-free and decoded fields.

## Test plan
- Reset, FIFO1 head 32'h0004_5678 (dest 24), both ready → lane1_valid=1, fifo1_pop=1; next cycle busy[24]=1.
- FIFO1 holds add dest 21 then instr with srcA=21 → second stalls until wb1_addr=21, issues cycle after wb, lane1_stalls counts stall cycles.
- Both heads memory ops (opcode 111), independent regs, repeated 4 cycles → grants alternate lane1, lane2, lane1, lane2.
- Lane2 head dest=lane1 head srcA, rr=1 → only lane2 issues; rr=0 next.
- halt_req=1 with two ops in flight → no issue, halt_ack=1 one cycle after last wb; halt_req=0 → issue resumes next cycle.
- resetn low mid-stall with busy bits set → pops 0 immediately, busy cleared, counters 0.
